p2s_shift: RTL
==============

# p2s_shift

Parallel-in / serial-out transmit shifter for the radix-2 FFT serial datapath. Accepts a `width`-bit word over a valid/ready handshake and emits it one bit per clock, LSB first, with a valid and last-bit marker. A word sent this way lands in the serial-in/parallel-out right shifter with its bit order unchanged after `width` shifts. It is the transmit end of the inter-stage serial links.

## Interface
- `width`, default 4: word width in bits; legal range ≥ 2.
- `clk`  in  1  clock; all logic on rising edge.
- `clr`  in  1  synchronous clear, active-high.
- `din`  in  width  parallel word to transmit.
- `in_valid`  in  1  `din` holds a word to send.
- `in_ready`  out  1  block can capture a word this cycle.
- `s_out`  out  1  serial data bit.
- `s_valid`  out  1  `s_out` carries a live bit.
- `s_last`  out  1  current bit is bit `width-1` of the word.

One clock, `clk`. Reset `clr` is synchronous and active-high.

## Operation
- Internal state:
  - `shreg[width-1:0]`.
  - `cnt`, a bit counter `$clog2(width)` bits wide.
  - `busy` flag.
- Accept: on an edge where `in_valid && in_ready`, do all of the following:
  - `shreg <= din`.
  - `cnt <= 0`.
  - `busy <= 1`.
- Shift: on an edge where `busy` is high and no accept occurs, do both:
  - `shreg <= {1'b0, shreg[width-1:1]}`.
  - `cnt <= cnt + 1`.
- Word end: `busy` clears on the edge that ends the cycle with `cnt == width-1`, unless an accept occurs on that same edge.
- Outputs are combinational from registered state:
  - `s_out = shreg[0]`.
  - `s_valid = busy`.
  - `s_last = busy && (cnt == width-1)`.
- Without `P2S_BACKTOBACK_EN`: `in_ready = !busy`.
- Bit order is LSB first. The receiver's MSB-entry right shift places the first bit at bit 0.
- `din` is sampled only on the accept edge; later changes on `din` do not affect the word in flight.
- `in_valid` while `in_ready` is low is ignored. The upstream block must hold `in_valid` and `din` until accepted.
- `clr` has priority over accept and shift. `clr` mid-word aborts the word and discards the remaining bits. No partial `s_last` is produced.

## Timing
- Reset values after the `clr` edge:
  - `shreg = 0`, `cnt = 0`, `busy = 0`.
  - Outputs: `s_out = 0`, `s_valid = 0`, `s_last = 0`, `in_ready = 1`.
- Latency: a word accepted at edge N presents bit 0 in cycle N+1. Bit k appears in cycle N+1+k.
- `s_last` is high in cycle N+width, for exactly one cycle per word.
- Without the macro: after a word ends there is one idle cycle (`s_valid = 0`, `in_ready = 1`). The next word therefore starts at the earliest `width+1` cycles after the previous one, for a throughput of `width` bits per `width+1` cycles.
- An accept is only possible when `in_ready = 1`.

## Configuration
- `P2S_BACKTOBACK_EN` defined:
  - `in_ready = !busy || s_last`.
  - An accept on the `s_last` edge reloads `shreg` and `cnt` and keeps `busy` high.
  - Result: gapless stream; `s_valid` is held high across words and words start every `width` cycles.
- `P2S_BACKTOBACK_EN` undefined: the behaviour in Operation and Timing applies, with the single idle cycle between words.

## Structure
- Shared package `fft_serial_pkg` holds:
  - function `cnt_w(width)`, defined as `max(1, $clog2(width))`.
  - default word-width constant `FFT_SER_WIDTH = 4`.
- Sub-module `p2s_bit_counter` provides the modulo-`width` counter. Ports: `clk`, `clr`, `load`, `inc`, `cnt`, `at_last`.
- The shift register stays inline.

## Test plan
- Reset: hold `clr` for 2 cycles with `in_valid = 1`, `din = 4'hF` → `s_valid = 0`, `s_out = 0`, `in_ready = 1`, no accept.
- Single word, `width = 4`, `din = 4'b1011` accepted at edge 0 → `s_out` = 1,1,0,1 in cycles 1–4, `s_valid = 1` throughout, `s_last` only in cycle 4, `in_ready = 0` in cycles 1–4.
- Two words without the macro, `4'hA` then `4'h5` with `in_valid` held high → bits 0,1,0,1, then one cycle with `s_valid = 0`, then 1,0,1,0; stall cycles honoured.
- Same two words with `P2S_BACKTOBACK_EN` → 8 consecutive valid bits 0,1,0,1,1,0,1,0, `s_last` in cycles 4 and 8.
- Abort: `clr` asserted in cycle 2 of word `4'hC` → from cycle 3, `s_valid = 0` and `in_ready = 1`; `s_last` is never asserted for that word.
- Loopback with `width = 8`: `s_out` drives the existing serial-in/parallel-out shifter, clocked on `s_valid` cycles, with 256 random words → captured word equals `din` every time.

Source files
------------

// File: rtl/fft_serial_pkg.sv
// fft_serial_pkg: shared width constant and counter-width helper for the FFT serial links
package fft_serial_pkg;
   localparam int FFT_SER_WIDTH = 4;
   function automatic int cnt_w(input int width);
      return ($clog2(width) > 1) ? $clog2(width) : 1;
   endfunction
endpackage

// File: rtl/p2s_shift_if.sv
// p2s_shift_if: parallel handshake in, serial bit stream out
//   din/in_valid/in_ready : word handshake (master drives din, in_valid)
//   s_out/s_valid/s_last  : serial bit, live-bit flag, last-bit marker
interface p2s_shift_if
   import fft_serial_pkg::*;
#(parameter int width = FFT_SER_WIDTH) ();
   logic [width-1:0] din;
   logic in_valid, in_ready, s_out, s_valid, s_last;
   modport master (output din, in_valid, input in_ready, s_out, s_valid, s_last);
   modport slave (input din, in_valid, output in_ready, s_out, s_valid, s_last);
endinterface

// File: rtl/p2s_bit_counter.sv
// p2s_bit_counter: modulo-width bit counter for the transmit shifter
//   clk, clr : clock, synchronous active-high clear
//   load     : restart at 0 (wins over inc)
//   inc      : advance, wrapping after width-1
//   cnt      : current bit index
//   at_last  : cnt == width-1
module p2s_bit_counter
   import fft_serial_pkg::*;
#(parameter int width = FFT_SER_WIDTH)
(
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    load,
   input  logic                    inc,
   output logic [cnt_w(width)-1:0] cnt,
   output logic                    at_last
);
   localparam int CW = cnt_w(width);
   localparam logic [CW-1:0] LAST = CW'(width - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? '0 : !inc ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk)
      if (clr) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt = cnt_q;
   assign at_last = cnt_q == LAST;
endmodule

// File: rtl/p2s_shift.sv
// p2s_shift: parallel-in/serial-out transmit shifter, LSB first
//   clk, clr : clock, synchronous active-high clear (priority over everything)
//   bus      : p2s_shift_if slave (din/in_valid/in_ready in, s_out/s_valid/s_last out)
//   P2S_BACKTOBACK_EN : when defined, a new word may load on the s_last cycle for a gapless stream
module p2s_shift
   import fft_serial_pkg::*;
#(parameter int width = FFT_SER_WIDTH)
(
   input  logic       clk,
   input  logic       clr,
   p2s_shift_if.slave bus
);
   localparam int CW = cnt_w(width);
   logic [width-1:0] shreg_q, shreg_d;
   logic busy_q, busy_d, accept, at_last;
   logic [CW-1:0] cnt;
   p2s_bit_counter #(.width(width)) u_cnt (
      .clk(clk), .clr(clr), .load(accept), .inc(busy_q && !accept), .cnt(cnt), .at_last(at_last)
   );
   always_comb begin
      bus.s_out = shreg_q[0];
      bus.s_valid = busy_q;
      bus.s_last = busy_q && (cnt == CW'(width - 1));
`ifdef P2S_BACKTOBACK_EN
      bus.in_ready = !busy_q || bus.s_last;
`else
      bus.in_ready = !busy_q;
`endif
      accept = bus.in_valid && bus.in_ready;
      shreg_d = accept ? bus.din : busy_q ? {1'b0, shreg_q[width-1:1]} : shreg_q;
      // an accept on the last bit keeps busy high; otherwise the last bit ends the word
      busy_d = accept || (busy_q && !at_last);
   end
   always_ff @(posedge clk)
      if (clr) begin
         shreg_q <= '0;
         busy_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         busy_q <= busy_d;
      end
endmodule
